oc8051_tc_multi: RTL

//  Parametrised multi-channel timer/counter for the oc8051 SFR space; successor to the fixed 2-channel 8051 T/C.

---
 rtl/oc8051_tc_multi.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/oc8051_tc_multi.sv
// rtl/oc8051_tc_multi.sv - multi-channel SFR timer/counter with reload, one-shot, prescaler and coherent reads
module oc8051_tc_multi #(
    parameter int         CHANNELS  = 2,
    parameter int         WIDTH     = 16,
    parameter logic [7:0] BASE_ADDR = 8'hC0,
    parameter int         PRESCALE  = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic                wr_bit,
    input  logic [7:0]          wr_addr,
    input  logic [7:0]          data_in,
    input  logic [7:0]          rd_addr,
    output logic [7:0]          data_out,
    input  logic [CHANNELS-1:0] t_in,
    input  logic [CHANNELS-1:0] gate_in,
    output logic [CHANNELS-1:0] tf,
    output logic [CHANNELS-1:0] irq
);

    localparam int         NB     = WIDTH / 8;
    localparam logic [4:0] CH_LIM = 5'(CHANNELS);
    localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

    logic [7:0]       ctrl   [CHANNELS];
    logic [WIDTH-1:0] cnt    [CHANNELS];
    logic [WIDTH-1:0] rld    [CHANNELS];
    logic [7:0]       presc  [CHANNELS];
    logic [15:0]      shadow [CHANNELS];

    logic [CHANNELS-1:0] t_s1, t_s2, t_s3, g_s1, g_s2;
    logic [CHANNELS-1:0] en, tick, ovf, cnt_wr, w_sel;

    logic [7:0] w_diff, r_diff;
    logic       w_dec, r_dec;
    logic [1:0] w_ch, r_ch;
    logic [2:0] w_off, r_off;
    logic [7:0] rd_next;
    logic       r_map;

    assign w_diff = wr_addr - BASE_ADDR;
    assign w_dec  = wr && !wr_bit && (wr_addr >= BASE_ADDR) && (w_diff[7:3] < CH_LIM);
    assign w_ch   = w_diff[4:3];
    assign w_off  = w_diff[2:0];

    assign r_diff = rd_addr - BASE_ADDR;
    assign r_dec  = (rd_addr >= BASE_ADDR) && (r_diff[7:3] < CH_LIM);
    assign r_ch   = r_diff[4:3];
    assign r_off  = r_diff[2:0];

    // A CNT byte write in the same cycle as a tick suppresses the tick, so it cannot overflow either.
    always_comb begin
        en     = '0;
        tick   = '0;
        ovf    = '0;
        cnt_wr = '0;
        w_sel  = '0;
        irq    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sel[c]  = w_dec && (w_ch == 2'(c));
            cnt_wr[c] = w_sel[c] && (w_off >= 3'd1) && (w_off <= 3'(NB));
            en[c]     = ctrl[c][0] && (!ctrl[c][1] || g_s2[c]);
            if (ctrl[c][2])
                tick[c] = en[c] && t_s3[c] && !t_s2[c];
            else if (ctrl[c][4:3] == 2'd3)
                tick[c] = en[c] && (presc[c] == PS_MAX);
            else
                tick[c] = en[c];
            ovf[c] = tick[c] && !cnt_wr[c] && (cnt[c] == {WIDTH{1'b1}});
            irq[c] = tf[c] && ctrl[c][7];
        end
    end

    always_comb begin
        rd_next = 8'h00;
        r_map   = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_dec && (r_ch == 2'(c))) begin
                case (r_off)
                    3'd0: begin rd_next = ctrl[c]; r_map = 1'b1; end
                    3'd1: begin rd_next = cnt[c][7:0]; r_map = 1'b1; end
                    3'd2: if (NB >= 2) begin rd_next = shadow[c][7:0]; r_map = 1'b1; end
                    3'd3: if (NB >= 3) begin rd_next = shadow[c][15:8]; r_map = 1'b1; end
                    3'd4: begin rd_next = rld[c][7:0]; r_map = 1'b1; end
                    3'd5: if (NB >= 2) begin rd_next = 8'(24'(rld[c]) >> 8); r_map = 1'b1; end
                    3'd6: if (NB >= 3) begin rd_next = 8'(24'(rld[c]) >> 16); r_map = 1'b1; end
                    default: begin rd_next = {7'b0, tf[c]}; r_map = 1'b1; end
                endcase
            end
        end
        if (r_map && w_dec && (wr_addr == rd_addr))
            rd_next = data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_s1     <= '0;
            t_s2     <= '0;
            t_s3     <= '0;
            g_s1     <= '0;
            g_s2     <= '0;
            tf       <= '0;
            data_out <= 8'h00;
            for (int c = 0; c < CHANNELS; c++) begin
                ctrl[c]   <= '0;
                cnt[c]    <= '0;
                rld[c]    <= '0;
                presc[c]  <= '0;
                shadow[c] <= '0;
            end
        end else begin
            t_s1     <= t_in;
            t_s2     <= t_s1;
            t_s3     <= t_s2;
            g_s1     <= gate_in;
            g_s2     <= g_s1;
            data_out <= rd_next;
            for (int c = 0; c < CHANNELS; c++) begin
                if (en[c] && (ctrl[c][4:3] == 2'd3))
                    presc[c] <= (presc[c] == PS_MAX) ? 8'd0 : presc[c] + 8'd1;
                else
                    presc[c] <= 8'd0;

                if (cnt_wr[c]) begin
                    for (int b = 0; b < NB; b++)
                        if (w_off == 3'(b + 1))
                            cnt[c][8*b +: 8] <= data_in;
                end else if (ovf[c]) begin
                    cnt[c] <= (ctrl[c][4:3] == 2'd1 || ctrl[c][4:3] == 2'd2) ? rld[c] : '0;
                end else if (tick[c]) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end

                for (int b = 0; b < NB; b++)
                    if (w_sel[c] && (w_off == 3'(b + 4)))
                        rld[c][8*b +: 8] <= data_in;

                // A CTRL write overrides the one-shot run clear in the same cycle.
                if (w_sel[c] && (w_off == 3'd0))
                    ctrl[c] <= data_in & 8'h9F;
                else if (ovf[c] && (ctrl[c][4:3] == 2'd2))
                    ctrl[c][0] <= 1'b0;

                if (ovf[c])
                    tf[c] <= 1'b1;
                else if (w_sel[c] && (w_off == 3'd7) && data_in[0])
                    tf[c] <= 1'b0;

                if (r_dec && (r_ch == 2'(c)) && (r_off == 3'd1))
                    shadow[c] <= 16'(24'(cnt[c]) >> 8);
            end
        end
    end

endmodule
